mux_arb_n: RTL and testbench
============================

Name: mux_arb_n

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshake and two selection modes: direct select or round-robin arbitration.
Successor to the fixed 8x8-bit combinational select used on the datapath.
Sits between multiple producers (register file ports, immediate path, I/O) and a single registered consumer such as an ALU operand or bus write port.
Output is registered: 1-cycle latency, full throughput.

Parameters:
WIDTH, 8, data width per channel in bits
N, 8, number of input channels (N >= 1)
SELW, max(1, $clog2(N)), select/channel-index width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready (one-hot or zero)
mode  input  1  0 = MODE_SEL (direct via sel), 1 = MODE_RR (round-robin)
sel  input  SELW  channel index used in MODE_SEL
out_data  output  WIDTH  registered selected data
out_chan  output  SELW  registered index of the channel that supplied out_data
out_valid  output  1  out_data/out_chan valid
out_ready  input  1  consumer accepts the output word

Behaviour:
- Reset (synchronous, on the clk edge while reset=1):
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer ptr=N-1, so channel 0 has first priority after reset.
  - in_ready forced to all-zero combinationally while reset=1.
- Reset mid-operation drops any held output word; no transfer is reported on that cycle.
- load = !out_valid || out_ready. The output register accepts a new word only when load=1.
- Grant, combinational from the current-cycle inputs:
  - MODE_SEL: grant=sel if sel<N and in_valid[sel]=1. If sel>=N, no grant and in_ready=0.
  - MODE_RR: grant = first i with in_valid[i]=1, searching ptr+1, ptr+2, ... with wrap modulo N. No grant if in_valid=0.
- Handshake:
  - in_ready[i] = load && grant_valid && (grant==i).
  - A channel transfer occurs when in_valid[i] && in_ready[i].
  - in_ready must not depend on in_data.
- On a transfer:
  - out_data <= in_data[grant].
  - out_chan <= grant.
  - out_valid <= 1.
  - In MODE_RR only, ptr <= grant. MODE_SEL transfers leave ptr unchanged.
- Output hold:
  - If out_valid && !out_ready, out_data, out_chan and out_valid are held stable and all in_ready=0 (no overwrite).
  - If out_ready=1 and no grant, out_valid <= 0 on the next edge.
- Simultaneous consume + load: when out_ready=1 and a grant exists in the same cycle, the new word replaces the old one. No bubble; throughput is 1 word per cycle.
- Latency: in_data sampled at edge k appears on out_data after edge k (1 cycle).
- mode and sel are sampled every cycle. A switch affects only the grant of that cycle and never alters a held output word.
- N=1: grant is always channel 0 when in_valid[0]=1. ptr is a constant 0.
- ptr wraps from N-1 to 0. Non-power-of-two N must never grant an index >= N.

Decomposition:
- Package mux_arb_pkg contains:
  - enum mode_e {MODE_SEL=1'b0, MODE_RR=1'b1}.
  - A function clog2_min1(n) used to derive SELW.
- Sub-module rr_pick #(N): combinational rotating priority encoder.
  - Inputs: req[N], ptr[SELW].
  - Outputs: gnt_idx[SELW], gnt_valid.
- The top level holds the handshake logic, ptr register and output register.

Test Plan:
- Reset/default (WIDTH=8, N=8): hold reset 2 cycles with in_valid=8'hFF, then check during and after reset:
  - During reset: in_ready=0, out_valid=0, out_data=0.
  - First RR grant after reset: channel 0.
- MODE_SEL: sel=5, in_valid=8'h20, ch5 data=8'hA5, out_ready=1 -> next cycle out_data=8'hA5, out_chan=5, out_valid=1. With sel=5 and in_valid[5]=0 -> no grant and out_valid drops to 0.
- MODE_RR fairness: in_valid=8'hFF held, out_ready=1 for 10 cycles -> out_chan sequence 0,1,2,...,7,0,1 with one word per cycle.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles while inputs change -> out_data and out_chan stable, in_ready=0. Raise out_ready -> the held word is consumed and the next grant is loaded in the same edge.
- Sparse RR with wrap: ptr=6, in_valid=8'b0000_0101 -> grant ch0. Next cycle (ptr=0) -> ch2. Then in_valid=0 -> out_valid falls to 0.
- Non-power-of-two (N=5, SELW=3): MODE_SEL with sel=6 and in_valid=5'h1F -> in_ready=0, no transfer. In MODE_RR the grant index never exceeds 4. Assert reset while out_valid=1 -> out_valid=0 on the next edge.

Source files
------------

// File: rtl/mux_arb_n_pkg.sv
// rtl/mux_arb_n_pkg.sv - shared types and helpers for the N-channel registered arbiter mux
// Contents: mode_e (select mode), clog2_min1 (index width, never below 1 bit).
package mux_arb_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Index width for n channels; a single channel still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// rtl/mux_arb_n_if.sv - handshake bundle between N producers and one registered consumer
// Signals: in_data/in_valid/in_ready (producer side), mode/sel (selection control),
//          out_data/out_chan/out_valid/out_ready (consumer side).
// Modports: slave = the arbiter, master = the environment driving it.
interface mux_arb_n_if
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 8,
    localparam int SELW  = clog2_min1(N)
) ();

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    mode_e              mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// rtl/mux_arb_n_rr_pick.sv - combinational rotating priority encoder
// Ports: req (per-channel request), ptr (last granted index),
//        gnt_idx (first requester after ptr, wrapping), gnt_valid (any request).
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter  int N    = 8,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_valid
);

    always_comb begin
        int idx;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // Search ptr+1 .. ptr+N; ptr itself is visited last. Wrap by subtraction
        // so non-power-of-two N never yields an index >= N.
        for (int k = 1; k <= N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_valid && req[idx]) begin
                gnt_idx   = SELW'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// rtl/mux_arb_n.sv - N-channel registered mux with direct-select or round-robin arbitration
// Ports: clk, reset (sync, active-high), bus (mux_arb_n_if.slave).
// One cycle latency, one word per cycle; a held output word blocks all inputs.
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 8,
    localparam int SELW  = clog2_min1(N)
) (
    input  logic        clk,
    input  logic        reset,
    mux_arb_n_if.slave  bus
);

    logic [SELW-1:0]    ptr;
    logic [SELW-1:0]    rr_idx;
    logic               rr_valid;
    logic [SELW-1:0]    grant;
    logic               grant_valid;
    logic               load;
    logic [N-1:0]       valid_at_sel;
    logic [N*WIDTH-1:0] data_shifted;
    logic [WIDTH-1:0]   grant_data;

    rr_pick #(.N(N)) u_rr_pick (
        .req       (bus.in_valid),
        .ptr       (ptr),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    assign load = !bus.out_valid || bus.out_ready;

    // Shifts keep out-of-range sel values from indexing past the vectors.
    assign valid_at_sel = bus.in_valid >> bus.sel;
    assign data_shifted = bus.in_data >> (int'(grant) * WIDTH);
    assign grant_data   = data_shifted[WIDTH-1:0];

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (bus.mode == MODE_RR) begin
            grant       = rr_idx;
            grant_valid = rr_valid;
        end else if (int'(bus.sel) < N && valid_at_sel[0]) begin
            grant       = bus.sel;
            grant_valid = 1'b1;
        end
    end

    // Ready never looks at in_data, only at validity, mode/sel and output state.
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = !reset && load && grant_valid && (int'(grant) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            ptr           <= SELW'(N - 1);
        end else if (load) begin
            if (grant_valid) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= grant_data;
                bus.out_chan  <= grant;
                if (bus.mode == MODE_RR) begin
                    ptr <= grant;
                end
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// tb/tb_mux_arb_n.sv - directed self-checking bench for mux_arb_n (N=8 and N=5 instances)
module tb_mux_arb_n;
    import mux_arb_pkg::*;

    logic clk;
    logic reset_a;
    logic reset_b;
    int   checks;
    int   failures;

    mux_arb_n_if #(.WIDTH(8), .N(8)) bus_a ();
    mux_arb_n_if #(.WIDTH(8), .N(5)) bus_b ();

    mux_arb_n #(.WIDTH(8), .N(8)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
    mux_arb_n #(.WIDTH(8), .N(5)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data_a(input logic [7:0] base);
        for (int i = 0; i < 8; i++) bus_a.in_data[i*8 +: 8] = base + 8'(i);
    endtask

    task automatic set_data_b(input logic [7:0] base);
        for (int i = 0; i < 5; i++) bus_b.in_data[i*8 +: 8] = base + 8'(i);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_a  = 1'b1;
        reset_b  = 1'b1;
        bus_a.in_valid  = 8'hFF;
        bus_a.mode      = MODE_RR;
        bus_a.sel       = '0;
        bus_a.out_ready = 1'b1;
        set_data_a(8'h10);
        bus_b.in_valid  = 5'h1F;
        bus_b.mode      = MODE_SEL;
        bus_b.sel       = 3'd6;
        bus_b.out_ready = 1'b1;
        set_data_b(8'h50);

        // Reset held two cycles with all channels requesting.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_in_ready", bus_a.in_ready, 8'h00);
            check("rst_out_valid", bus_a.out_valid, 0);
            check("rst_out_data", bus_a.out_data, 0);
        end
        reset_a = 1'b0;
        #1;
        check("first_rr_ready", bus_a.in_ready, 8'h01);

        // Round-robin fairness: 0..7,0,1 one word per cycle.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rr_chan", bus_a.out_chan, i % 8);
            check("rr_data", bus_a.out_data, 8'h10 + (i % 8));
            check("rr_valid", bus_a.out_valid, 1);
        end

        // Backpressure: held word ch1/0x11 while inputs and data change.
        bus_a.out_ready = 1'b0;
        set_data_a(8'h20);
        for (int j = 0; j < 3; j++) begin
            bus_a.in_valid = 8'h0F << j;
            #1;
            check("bp_in_ready", bus_a.in_ready, 8'h00);
            tick();
            check("bp_chan", bus_a.out_chan, 1);
            check("bp_data", bus_a.out_data, 8'h11);
            check("bp_valid", bus_a.out_valid, 1);
        end
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 8'hFF;
        #1;
        check("bp_release_ready", bus_a.in_ready, 8'h04);
        tick();
        check("bp_release_chan", bus_a.out_chan, 2);
        check("bp_release_data", bus_a.out_data, 8'h22);

        // Direct select.
        bus_a.mode = MODE_SEL;
        bus_a.sel  = 3'd5;
        bus_a.in_valid = 8'h20;
        bus_a.in_data[40 +: 8] = 8'hA5;
        #1;
        check("sel_ready", bus_a.in_ready, 8'h20);
        tick();
        check("sel_data", bus_a.out_data, 8'hA5);
        check("sel_chan", bus_a.out_chan, 5);
        check("sel_valid", bus_a.out_valid, 1);
        bus_a.in_valid = 8'h00;
        #1;
        check("sel_idle_ready", bus_a.in_ready, 8'h00);
        tick();
        check("sel_idle_valid", bus_a.out_valid, 0);

        // Sparse RR with wrap: ptr stays 2 across the select transfers, ch6 sets ptr=6.
        bus_a.mode = MODE_RR;
        bus_a.in_valid = 8'h40;
        tick();
        check("sparse_ch6", bus_a.out_chan, 6);
        bus_a.in_valid = 8'b0000_0101;
        #1;
        check("sparse_wrap_ready", bus_a.in_ready, 8'h01);
        tick();
        check("sparse_wrap_chan", bus_a.out_chan, 0);
        check("sparse_next_ready", bus_a.in_ready, 8'h04);
        tick();
        check("sparse_next_chan", bus_a.out_chan, 2);
        bus_a.in_valid = 8'h00;
        tick();
        check("sparse_drain_valid", bus_a.out_valid, 0);

        // N=5: out-of-range sel never grants.
        check("b_rst_ready", bus_b.in_ready, 5'h00);
        reset_b = 1'b0;
        #1;
        check("b_sel6_ready", bus_b.in_ready, 5'h00);
        tick();
        check("b_sel6_valid", bus_b.out_valid, 0);
        bus_b.mode = MODE_RR;
        #1;
        check("b_rr_first_ready", bus_b.in_ready, 5'h01);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("b_rr_chan", bus_b.out_chan, i % 5);
            check("b_rr_data", bus_b.out_data, 8'h50 + (i % 5));
        end

        // Reset while a word is held drops it.
        bus_b.out_ready = 1'b0;
        reset_b = 1'b1;
        #1;
        check("b_rst_mid_ready", bus_b.in_ready, 5'h00);
        tick();
        check("b_rst_mid_valid", bus_b.out_valid, 0);
        check("b_rst_mid_data", bus_b.out_data, 0);
        check("b_rst_mid_chan", bus_b.out_chan, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
